// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the WB write-port arbiter: register widths,
// the buffered mul/div result entry and the arbiter FSM states.
package cpu_defs;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // One buffered mul/div result; live drops when a younger WB write
    // to the same register makes the result obsolete.
    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle around the register-file write port arbiter: WB request,
// mul/div result handshake, RF write port, ID hazard query and freeze.
interface wb_port_arbiter_if #(
    parameter int ADDR_W = cpu_defs::ADDR_W,
    parameter int DATA_W = cpu_defs::DATA_W
);
    logic              wb_we;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              md_valid;
    logic [ADDR_W-1:0] md_dest;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              md_hazard;
    logic              freeze;

    // The arbiter side.
    modport slave (
        input  wb_we, wb_dest, wb_data, md_valid, md_dest, md_data, id_rs, id_rt,
        output md_ready, rf_we, rf_waddr, rf_wdata, md_hazard, freeze
    );

    // The pipeline / mul-div / register-file side.
    modport master (
        output wb_we, wb_dest, wb_data, md_valid, md_dest, md_data, id_rs, id_rt,
        input  md_ready, rf_we, rf_waddr, rf_wdata, md_hazard, freeze
    );
endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Small circular buffer of mul/div results waiting for an idle WB slot.
// Entries can be killed by destination (WAW with a younger WB write);
// a live-destination mask feeds ID hazard detection.
module wb_result_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    input  logic                       kill_en,
    input  logic [ADDR_W-1:0]          kill_dest,
    output wb_entry_t                  head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [(1<<ADDR_W)-1:0]     live_mask
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  live_q, live_d;
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Next pointers, occupancy and per-entry live bits (kill, pop, push).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        live_d   = live_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dest_q[i] == kill_dest) live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            // A WB write to the same register this cycle supersedes the result on entry.
            live_d[wr_ptr_q] = push_entry.live && !(kill_en && kill_dest == push_entry.dest);
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state: pointers, count and live bits are cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    // Payload storage, written only on push.
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; live bits alone decide whether an entry means anything.
        if (push) begin
            dest_q[wr_ptr_q] <= push_entry.dest;
            data_q[wr_ptr_q] <= push_entry.data;
        end
    end

    // Head view and live-destination mask from registered contents.
    always_comb begin
        head      = '{live: live_q[rd_ptr_q], dest: dest_q[rd_ptr_q], data: data_q[rd_ptr_q]};
        live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) live_mask[dest_q[i]] = 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the WB stage always wins; mul/div
// results bypass into an idle port or wait in a FIFO, and freeze forces
// a bubble once the FIFO head has waited too long.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_W       = cpu_defs::DATA_W,
    parameter int ADDR_W       = cpu_defs::ADDR_W
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    import cpu_defs::wb_entry_t;
    import cpu_defs::arb_state_e;
    import cpu_defs::IDLE;
    import cpu_defs::WAIT;
    import cpu_defs::FORCE;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG  = 1 << ADDR_W;

    wb_entry_t        head, push_entry;
    logic [CNT_W-1:0] fifo_count, count_after;
    logic [NREG-1:0]  pending_mask;
    logic             head_valid, md_ready, bypass, push, pop;
    arb_state_e       state_q, state_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             freeze_q, freeze_d;

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (bus.wb_we),
        .kill_dest  (bus.wb_dest),
        .head       (head),
        .count      (fifo_count),
        .live_mask  (pending_mask)
    );

    // Write-port mux: WB first, then FIFO head, then direct mul/div bypass.
    always_comb begin
        head_valid   = (fifo_count != '0);
        md_ready     = (fifo_count < CNT_W'(DEPTH));
        bypass       = 1'b0;
        pop          = 1'b0;
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = {DATA_W{1'b0}};
        if (bus.wb_we) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.wb_dest;
            bus.rf_wdata = bus.wb_data;
            // A dead head needs no port slot, so it can retire now.
            pop          = head_valid && !head.live;
        end else if (head_valid) begin
            pop          = 1'b1;
            bus.rf_we    = head.live;
            bus.rf_waddr = head.dest;
            bus.rf_wdata = head.data;
        end else if (bus.md_valid) begin
            bypass       = 1'b1;
            bus.rf_we    = (bus.md_dest != '0);
            bus.rf_waddr = bus.md_dest;
            bus.rf_wdata = bus.md_data;
        end
        // r0 results are accepted but never stored.
        push        = bus.md_valid && md_ready && !bypass && (bus.md_dest != '0);
        push_entry  = '{live: 1'b1, dest: bus.md_dest, data: bus.md_data};
        count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
    end

    // Starvation FSM: age the waiting head, force a bubble at the limit.
    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        case (state_q)
            IDLE: begin
                age_d = '0;
                if (push) state_d = WAIT;
            end
            WAIT: begin
                if (pop) begin
                    age_d = '0;
                    if (count_after == '0) state_d = IDLE;
                end else if (age_q == AGE_W'(STARVE_LIMIT - 1)) begin
                    age_d   = '0;
                    state_d = FORCE;
                end else begin
                    age_d = age_q + AGE_W'(1);
                end
            end
            FORCE: begin
                if (pop) begin
                    age_d   = '0;
                    state_d = (count_after == '0) ? IDLE : WAIT;
                end
            end
            default: begin
                age_d   = '0;
                state_d = IDLE;
            end
        endcase
        freeze_d = (state_d == FORCE);
    end

    // FSM, age and registered freeze.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            age_q    <= '0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            age_q    <= age_d;
            freeze_q <= freeze_d;
        end
    end

    assign bus.md_ready  = md_ready;
    assign bus.freeze    = freeze_q;
    assign bus.md_hazard = ((bus.id_rs != '0) && pending_mask[bus.id_rs]) ||
                           ((bus.id_rt != '0) && pending_mask[bus.id_rt]);

endmodule
